// File: rtl/uart_core.sv
// uart_core: 8N1 UART transceiver with a shared 16x oversampling baud tick
// and 2^FIFO_W-deep TX/RX FIFOs between the serial pins and a byte-wide host port.
module uart_core #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 163,
  parameter int DVSR_BIT = 8,
  parameter int FIFO_W   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_uart,
  input  logic       wr_uart,
  input  logic       rx,
  input  logic [7:0] w_data,
  output logic       tx_full,
  output logic       rx_empty,
  output logic       tx,
  output logic [7:0] r_data
);
  localparam int DEPTH = 1 << FIFO_W;
  localparam int SW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [DVSR_BIT-1:0] BAUD_LAST = DVSR_BIT'(DVSR - 1);
  localparam logic [SW-1:0]       T_MID     = SW'(7);
  localparam logic [SW-1:0]       T_BIT     = SW'(15);
  localparam logic [SW-1:0]       T_STOP    = SW'(SB_TICK - 1);
  localparam logic [NW-1:0]       N_LAST    = NW'(DBIT - 1);
  localparam logic [FIFO_W-1:0]   PONE      = FIFO_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [DVSR_BIT-1:0] baud_q;
  logic                tick;

  always_ff @(posedge clk) begin
    if (reset)                  baud_q <= '0;
    else if (baud_q == BAUD_LAST) baud_q <= '0;
    else                        baud_q <= baud_q + DVSR_BIT'(1);
  end
  assign tick = (baud_q == BAUD_LAST);

  // TX FIFO
  logic [7:0]        tx_mem_q [DEPTH];
  logic [FIFO_W-1:0] tx_wptr_q, tx_rptr_q;
  logic              tx_full_q, tx_empty_q;
  logic              tx_push, tx_pop;
  state_e            tx_st_q;

  assign tx_push = wr_uart && !tx_full_q;
  assign tx_pop  = (tx_st_q == IDLE) && !tx_empty_q;

  // Gating push by full and pop by empty covers the simultaneous-access cases:
  // empty+both -> write only, full+both -> read only, otherwise both advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_mem_q   <= '{default: '0};
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_full_q  <= 1'b0;
      tx_empty_q <= 1'b1;
    end else begin
      if (tx_push) begin
        tx_mem_q[tx_wptr_q] <= w_data;
        tx_wptr_q           <= tx_wptr_q + PONE;
      end
      if (tx_pop) tx_rptr_q <= tx_rptr_q + PONE;
      if (tx_push && !tx_pop) begin
        tx_empty_q <= 1'b0;
        tx_full_q  <= (tx_wptr_q + PONE) == tx_rptr_q;
      end else if (tx_pop && !tx_push) begin
        tx_full_q  <= 1'b0;
        tx_empty_q <= (tx_rptr_q + PONE) == tx_wptr_q;
      end
    end
  end

  // TX FSM
  logic [SW-1:0] tx_s_q;
  logic [NW-1:0] tx_n_q;
  logic [7:0]    tx_b_q;
  logic          tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q <= IDLE;
      tx_s_q  <= '0;
      tx_n_q  <= '0;
      tx_b_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (tx_st_q)
        IDLE: if (!tx_empty_q) begin
          tx_b_q  <= tx_mem_q[tx_rptr_q];
          tx_s_q  <= '0;
          tx_q    <= 1'b0;
          tx_st_q <= START;
        end
        START: if (tick) begin
          if (tx_s_q == T_BIT) begin
            tx_s_q  <= '0;
            tx_n_q  <= '0;
            tx_q    <= tx_b_q[0];
            tx_st_q <= DATA;
          end else tx_s_q <= tx_s_q + SW'(1);
        end
        DATA: if (tick) begin
          if (tx_s_q == T_BIT) begin
            tx_s_q <= '0;
            tx_b_q <= {1'b0, tx_b_q[7:1]};
            if (tx_n_q == N_LAST) begin
              tx_q    <= 1'b1;
              tx_st_q <= STOP;
            end else begin
              tx_n_q <= tx_n_q + NW'(1);
              tx_q   <= tx_b_q[1];
            end
          end else tx_s_q <= tx_s_q + SW'(1);
        end
        STOP: if (tick) begin
          if (tx_s_q == T_STOP) tx_st_q <= IDLE;
          else                  tx_s_q  <= tx_s_q + SW'(1);
        end
        default: tx_st_q <= IDLE;
      endcase
    end
  end

  // RX synchronizer and FSM
  logic          rx_s1_q, rx_s2_q;
  state_e        rx_st_q;
  logic [SW-1:0] rx_s_q;
  logic [NW-1:0] rx_n_q;
  logic [7:0]    rx_b_q;
  logic          rx_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_st_q   <= IDLE;
      rx_s_q    <= '0;
      rx_n_q    <= '0;
      rx_b_q    <= '0;
      rx_done_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_done_q <= 1'b0;
      unique case (rx_st_q)
        IDLE: if (!rx_s2_q) begin
          rx_s_q  <= '0;
          rx_st_q <= START;
        end
        START: if (tick) begin
          if (rx_s_q == T_MID) begin
            rx_s_q  <= '0;
            rx_n_q  <= '0;
            rx_st_q <= DATA;
          end else rx_s_q <= rx_s_q + SW'(1);
        end
        DATA: if (tick) begin
          if (rx_s_q == T_BIT) begin
            rx_s_q <= '0;
            rx_b_q <= {rx_s2_q, rx_b_q[7:1]};
            if (rx_n_q == N_LAST) rx_st_q <= STOP;
            else                  rx_n_q  <= rx_n_q + NW'(1);
          end else rx_s_q <= rx_s_q + SW'(1);
        end
        STOP: if (tick) begin
          if (rx_s_q == T_STOP) begin
            rx_done_q <= 1'b1;
            rx_st_q   <= IDLE;
          end else rx_s_q <= rx_s_q + SW'(1);
        end
        default: rx_st_q <= IDLE;
      endcase
    end
  end

  // RX FIFO
  logic [7:0]        rx_mem_q [DEPTH];
  logic [FIFO_W-1:0] rx_wptr_q, rx_rptr_q;
  logic              rx_full_q, rx_empty_q;
  logic              rx_push, rx_pop;

  assign rx_push = rx_done_q && !rx_full_q;
  assign rx_pop  = rd_uart && !rx_empty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_mem_q   <= '{default: '0};
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_full_q  <= 1'b0;
      rx_empty_q <= 1'b1;
    end else begin
      if (rx_push) begin
        rx_mem_q[rx_wptr_q] <= rx_b_q;
        rx_wptr_q           <= rx_wptr_q + PONE;
      end
      if (rx_pop) rx_rptr_q <= rx_rptr_q + PONE;
      if (rx_push && !rx_pop) begin
        rx_empty_q <= 1'b0;
        rx_full_q  <= (rx_wptr_q + PONE) == rx_rptr_q;
      end else if (rx_pop && !rx_push) begin
        rx_full_q  <= 1'b0;
        rx_empty_q <= (rx_rptr_q + PONE) == rx_wptr_q;
      end
    end
  end

  assign tx       = tx_q;
  assign tx_full  = tx_full_q;
  assign rx_empty = rx_empty_q;
  assign r_data   = rx_mem_q[rx_rptr_q];

endmodule

// File: tb/tb_uart_core.sv
// Two cross-connected uart_core instances (fast baud) checked against a
// queue-based model of the serial frame, FIFO capacity and byte ordering.
module tb_uart_core;
  localparam int DVSR = 4;
  localparam int BIT  = 16 * DVSR;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd1, wr1, rd2, wr2;
  logic [7:0] wd1, wd2, rdat1, rdat2;
  logic       txf1, txf2, rxe1, rxe2, tx1, tx2;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  always #5 clk = ~clk;

  uart_core #(.DVSR(DVSR), .DVSR_BIT(8)) u1 (
    .clk(clk), .reset(reset), .rd_uart(rd1), .wr_uart(wr1), .rx(tx2),
    .w_data(wd1), .tx_full(txf1), .rx_empty(rxe1), .tx(tx1), .r_data(rdat1));

  uart_core #(.DVSR(DVSR), .DVSR_BIT(8)) u2 (
    .clk(clk), .reset(reset), .rd_uart(rd2), .wr_uart(wr2), .rx(tx1),
    .w_data(wd2), .tx_full(txf2), .rx_empty(rxe2), .tx(tx2), .r_data(rdat2));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    wd1 = b;
    wr1 = 1'b1;
    @(negedge clk);
    wr1 = 1'b0;
  endtask

  task automatic pop2();
    rd2 = 1'b1;
    @(negedge clk);
    rd2 = 1'b0;
  endtask

  task automatic wait_rx2(output bit ok);
    int t;
    t = 0;
    while (rxe2 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = !rxe2;
  endtask

  task automatic wait_fall(output bit ok);
    int t;
    t = 0;
    while (tx1 !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (tx1 === 1'b0);
  endtask

  // The start bit may be up to one tick short, so sampling points sit at
  // nominal bit centres measured from the falling edge.
  task automatic check_frame(input logic [7:0] b);
    bit         ok;
    logic [7:0] got;
    wait_fall(ok);
    check("tx_start_seen", 8'(ok), 8'd1);
    if (ok) begin
      repeat (BIT / 2) @(negedge clk);
      check("tx_start_bit", 8'(tx1), 8'd0);
      got = '0;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        got[i] = tx1;
      end
      check("tx_data_bits", got, b);
      repeat (BIT) @(negedge clk);
      check("tx_stop_bit", 8'(tx1), 8'd1);
    end
  endtask

  task automatic model_rx_push(input logic [7:0] b);
    if (exp_rx.size() < 4) exp_rx.push_back(b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=00 exp=01");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    int         room;
    int         lows;
    logic [7:0] b;
    logic [7:0] burst [6];

    reset = 1'b1;
    rd1 = 1'b0; wr1 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
    wd1 = '0; wd2 = '0;

    // Reset values
    @(negedge clk);
    check("rst_tx_during", 8'(tx1), 8'd1);
    check("rst_rxe_during", 8'(rxe2), 8'd1);
    check("rst_txf_during", 8'(txf1), 8'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_after", 8'(tx1), 8'd1);
    check("rst_rxe_after", 8'(rxe2), 8'd1);
    check("rst_txf_after", 8'(txf1), 8'd0);
    check("rst_rdata", rdat2, 8'h00);

    // Single-byte loopback, 0x41 then random bytes
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h41 : 8'($urandom);
      push1(b);
      model_rx_push(b);
      check_frame(b);
      wait_rx2(ok);
      check("loop_arrive", 8'(ok), 8'd1);
      check("loop_rdata", rdat2, exp_rx.pop_front());
      pop2();
      check("loop_drained", 8'(rxe2), 8'(exp_rx.size() == 0));
    end

    // Two bytes queued at the receiver
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom);
      push1(b);
      model_rx_push(b);
      repeat (1000) @(negedge clk);
    end
    check("two_nonempty", 8'(rxe2), 8'd0);
    check("two_first", rdat2, exp_rx.pop_front());
    pop2();
    check("two_second", rdat2, exp_rx[0]);
    check("two_still_nonempty", 8'(rxe2), 8'd0);
    void'(exp_rx.pop_front());
    pop2();
    check("two_empty", 8'(rxe2), 8'd1);

    // TX FIFO fill: four slots plus the shifter of an idle transmitter
    room = 5;
    for (int k = 0; k < 6; k++) burst[k] = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      wd1 = burst[k];
      wr1 = 1'b1;
      if (room > 0) begin
        exp_tx.push_back(burst[k]);
        room--;
      end
      @(negedge clk);
      check($sformatf("fill_txfull_%0d", k), 8'(txf1), 8'(room == 0));
    end
    wr1 = 1'b0;
    while (exp_tx.size() > 0) begin
      wait_rx2(ok);
      check("fill_arrive", 8'(ok), 8'd1);
      check("fill_rdata", rdat2, exp_tx.pop_front());
      pop2();
    end
    repeat (1500) @(negedge clk);
    check("fill_sixth_dropped", 8'(rxe2), 8'd1);
    check("fill_txfull_clear", 8'(txf1), 8'd0);

    // RX overflow: five frames, no reads
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      push1(b);
      model_rx_push(b);
    end
    repeat (5 * 700 + 800) @(negedge clk);
    check("ovf_nonempty", 8'(rxe2), 8'd0);
    while (exp_rx.size() > 0) begin
      check("ovf_rdata", rdat2, exp_rx.pop_front());
      pop2();
    end
    check("ovf_fifth_dropped", 8'(rxe2), 8'd1);

    // Reset in the middle of the data bits
    push1(8'($urandom));
    wait_fall(ok);
    check("mid_start_seen", 8'(ok), 8'd1);
    repeat (3 * BIT) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_tx_immediate", 8'(tx1), 8'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      if (tx1 !== 1'b1) lows++;
    end
    check("mid_tx_idle", 8'(lows), 8'd0);
    check("mid_peer_empty", 8'(rxe2), 8'd1);
    check("mid_own_rx_empty", 8'(rxe1), 8'd1);
    check("mid_txfull", 8'(txf1), 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
